// File: rtl/console_tap_pkg.sv
// Shared constants for the bus console tap: default decode addresses and
// the layout of the console status word returned on console reads.
package console_tap_pkg;

  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_0FF0;

  // Console status word: {reserved, FIFO depth, current fill count}
  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  depth;
    logic [7:0]  count;
  } status_t;

  function automatic logic [31:0] pack_status(input logic [7:0] depth,
                                              input logic [7:0] count);
    status_t s;
    s.rsvd  = '0;
    s.depth = depth;
    s.count = count;
    return s;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Circular character FIFO. Push is refused while full (full is registered);
// pop is ignored while empty. Storage is not reset, only pointers/count.
// Handshake: an entry moves out when valid & pop; an entry moves in when
// push & ~full, both evaluated at the rising CLK edge.
module char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [7:0]               push_data,
  output logic                     full,
  input  logic                     pop,
  output logic                     valid,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign valid   = (count_q != '0);
  assign data    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & valid;

  // Next-state for storage, pointers (natural wrap) and fill count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Character storage, deliberately not reset
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bus_console_tap.sv
// Generic-bus tap between the core and RAM. Console writes go to a
// character FIFO drained on char_*; console reads return FIFO status.
// Optional tohost register enabled by CONSOLE_TAP_TOHOST_EN.
// Core handshake: a request (m_ren or m_wen) completes in the cycle where
// m_busy is 0; tap-local accesses complete combinationally, RAM accesses
// follow s_busy. m_busy is 1 when no strobe is present.
module bus_console_tap
  import console_tap_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR,
  parameter logic [31:0] TOHOST_ADDR  = DEFAULT_TOHOST_ADDR,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_ren,
  input  logic        m_wen,
  input  logic [3:0]  m_byte_en,
  output logic [31:0] m_rdata,
  output logic        m_busy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_ren,
  output logic        s_wen,
  output logic [3:0]  s_byte_en,
  input  logic [31:0] s_rdata,
  input  logic        s_busy,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        done,
  output logic [31:0] done_code
);

  logic                        hit_con;
  logic                        hit_th;
  logic                        th_sel;
  logic                        hit_any;
  logic                        con_push;
  logic                        fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign hit_con  = (m_addr == CONSOLE_ADDR);
  assign th_sel   = hit_th & ~hit_con;
  assign hit_any  = hit_con | hit_th;
  assign con_push = m_wen & hit_con;

  char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (con_push),
    .push_data (m_wdata[31:24]),
    .full      (fifo_full),
    .pop       (char_ready),
    .valid     (char_valid),
    .data      (char_data),
    .count     (fifo_count)
  );

`ifdef CONSOLE_TAP_TOHOST_EN
  logic        done_q, done_d;
  logic [31:0] done_code_q, done_code_d;

  assign hit_th = (m_addr == TOHOST_ADDR);

  // Capture tohost writes; done is sticky until reset
  always_comb begin
    done_d      = done_q;
    done_code_d = done_code_q;
    if (m_wen && th_sel) begin
      done_d      = 1'b1;
      done_code_d = m_wdata;
    end
  end

  // Tohost registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      done_q      <= 1'b0;
      done_code_q <= '0;
    end else begin
      done_q      <= done_d;
      done_code_q <= done_code_d;
    end
  end

  assign done      = done_q;
  assign done_code = done_code_q;
`else
  // Tohost decode disabled; the compare only keeps the address parameter live
  assign hit_th    = (m_addr == TOHOST_ADDR) & 1'b0;
  assign done      = 1'b0;
  assign done_code = '0;
`endif

  // Request decode and response mux; write wins when both strobes are high
  always_comb begin
    s_addr    = m_addr;
    s_wdata   = m_wdata;
    s_byte_en = m_byte_en;
    s_ren     = m_ren & ~hit_any;
    s_wen     = m_wen & ~hit_any;
    m_rdata   = s_rdata;
    m_busy    = s_busy;
    if (!m_ren && !m_wen) begin
      m_busy = 1'b1;
    end else if (m_wen) begin
      if (hit_con) begin
        m_busy = fifo_full;
      end else if (th_sel) begin
        m_busy = 1'b0;
      end
    end else begin
      if (hit_con) begin
        m_busy  = 1'b0;
        m_rdata = pack_status(8'(FIFO_DEPTH), 8'(fifo_count));
      end else if (th_sel) begin
        m_busy  = 1'b0;
        m_rdata = done_code;
      end
    end
  end

endmodule
